// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtraction adds ~B with an initial carry of 1; Cout is "no borrow" in sub mode.
module serial_add_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_s;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c;

  always_comb begin
    w_s = r_a[0] ^ r_b[0] ^ r_c;
    w_c = (r_a[0] & r_b[0]) | (r_c & (r_a[0] ^ r_b[0]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= sub ? ~B : B;
            r_c     <= sub;
            r_cnt   <= '0;
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          // Result bits enter at the MSB so bit i lands at S[i] after WIDTH shifts.
          r_s   <= {w_s, r_s[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_cout  <= w_c;
            r_ovf   <= r_c ^ w_c;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign S    = r_s;
  assign Cout = r_cout;
  assign Ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8) with a result scoreboard.
module tb_serial_add_sub;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         Ovf;

  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .A    (A),
    .B    (B),
    .busy (busy),
    .done (done),
    .S    (S),
    .Cout (Cout),
    .Ovf  (Ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb     = sb ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, sb};
    e.s    = full[W-1:0];
    e.cout = full[W];
    if (sb) e.ovf = (a[W-1] != b[W-1]) && (e.s[W-1] != a[W-1]);
    else    e.ovf = (a[W-1] == b[W-1]) && (e.s[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at a negedge with the DUT idle; leaves at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sb, input string name);
    int   lat;
    exp_t e;
    A = a; B = b; sub = sb; start = 1'b1;
    q.push_back(model(a, b, sb));
    @(negedge clk);
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); sub = 1'($urandom);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s accept: busy=%b done=%b required busy=1 done=0", name, busy, done);
    end
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      void'(q.pop_front());
      return;
    end
    if (lat != 8) begin
      errors++;
      $display("FAIL %s latency: got %0d required 8", name, lat);
    end
    e = q.pop_front();
    checks++;
    if (S !== e.s || Cout !== e.cout || Ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s result: S=%h Cout=%b Ovf=%b required S=%h Cout=%b Ovf=%b",
               name, S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || S !== e.s || Cout !== e.cout || Ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s hold: done=%b busy=%b S=%h Cout=%b Ovf=%b required 0 0 %h %b %b",
               name, done, busy, S, Cout, Ovf, e.s, e.cout, e.ovf);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0",
               busy, done, S, Cout, Ovf);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    run_op(8'h0F, 8'h01, 1'b0, "add_0f_01");
  endtask

  task automatic test_carry_ovf;
    run_op(8'hFF, 8'h01, 1'b0, "add_ff_01");
    run_op(8'h7F, 8'h01, 1'b0, "add_7f_01");
  endtask

  task automatic test_sub;
    run_op(8'h05, 8'h07, 1'b1, "sub_05_07");
    run_op(8'h80, 8'h01, 1'b1, "sub_80_01");
  endtask

  task automatic test_ignore_start;
    int   n_done;
    int   n_busy;
    int   done_at;
    exp_t e;
    n_done = 0; n_busy = 0; done_at = -1;
    A = 8'h10; B = 8'h20; sub = 1'b0; start = 1'b1;
    q.push_back(model(8'h10, 8'h20, 1'b0));
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        n_done++;
        done_at = k;
        e = q.pop_front();
        checks++;
        if (S !== e.s) begin
          errors++;
          $display("FAIL ignore_result: S=%h required %h", S, e.s);
        end
      end
      if (k + 1 == 3 || k + 1 == 5) begin
        A = 8'h01; B = 8'h01; sub = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    checks++;
    if (n_done != 1 || done_at != 8) begin
      errors++;
      $display("FAIL ignore_done: count=%0d at=%0d required count=1 at=8", n_done, done_at);
    end
    checks++;
    if (n_busy != 9) begin
      errors++;
      $display("FAIL ignore_busy: busy cycles=%0d required 9", n_busy);
    end
    if (q.size() != 0) q.delete();
  endtask

  task automatic test_reset_abort;
    int n_done;
    int n_busy;
    n_done = 0; n_busy = 0;
    A = 8'h55; B = 8'h11; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || S !== '0 || Cout !== 1'b0 || Ovf !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b done=%b S=%h Cout=%b Ovf=%b required all 0",
               busy, done, S, Cout, Ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
      if (busy === 1'b1) n_busy++;
    end
    checks++;
    if (n_done != 0 || n_busy != 0) begin
      errors++;
      $display("FAIL abort_quiet: done=%0d busy=%0d required 0 0", n_done, n_busy);
    end
    run_op(8'h03, 8'h04, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back;
    int   n_done;
    int   last_done;
    logic prev_busy;
    exp_t e;
    n_done = 0; last_done = -1; prev_busy = 1'b0;
    A = 8'h3C; B = 8'h5A; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev_busy === 1'b0) q.push_back(model(8'h3C, 8'h5A, 1'b0));
      prev_busy = busy;
      if (done === 1'b1) begin
        n_done++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL b2b_unexpected_done at cycle %0d", k);
        end else begin
          e = q.pop_front();
          if (S !== e.s || Cout !== e.cout || Ovf !== e.ovf) begin
            errors++;
            $display("FAIL b2b_result: S=%h Cout=%b Ovf=%b required %h %b %b",
                     S, Cout, Ovf, e.s, e.cout, e.ovf);
          end
        end
        if (last_done >= 0) begin
          checks++;
          if (k - last_done != 10) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d required 10", k - last_done);
          end
        end
        last_done = k;
      end
      if (k == 25) start = 1'b0;
    end
    checks++;
    if (n_done != 3 || q.size() != 0) begin
      errors++;
      $display("FAIL b2b_count: dones=%0d pending=%0d required 3 0", n_done, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_carry_ovf();
    test_sub();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation, sampled on the rising clk edge.
REQ-005 SHALL have port: sub  input  1  0 = A+B, 1 = A-B, sampled with start.
REQ-006 SHALL have port: A  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port: B  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port: busy  output  1  high while an operation is in progress or completing.
REQ-009 SHALL have port: done  output  1  single-cycle completion pulse.
REQ-010 SHALL have port: S  output  WIDTH  result register.
REQ-011 SHALL have port: Cout  output  1  final carry out (sub mode: 1 = no borrow).
REQ-012 SHALL have port: Ovf  output  1  two's-complement signed overflow flag.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 In IDLE, a clk edge with start=1 SHALL accept the request: load A into the A shift register, load B (sub=0) or ~B (sub=1) into the B shift register, set the carry register to sub, clear the bit counter, and enter RUN.
REQ-015 On acceptance, S, Cout and Ovf SHALL be cleared to 0.
REQ-016 In RUN, each edge SHALL process exactly one bit, LSB first, using the full-adder equations: s = a^b^c; c' = (a&b)|(c&(a^b)).
REQ-017 The s bit SHALL be shifted into S from the MSB end, so that after WIDTH bits S[i] holds result bit i.
REQ-018 RUN SHALL last exactly WIDTH edges; the edge that processes bit WIDTH-1 SHALL move the FSM to DONE.
REQ-019 On that same edge, the final carry SHALL be written to Cout.
REQ-020 On that same edge, Ovf SHALL be written with (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-021 done SHALL be 1 only while in DONE, i.e. for exactly one cycle, asserted WIDTH cycles after the accepting edge.
REQ-022 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-023 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored while busy=1, including in DONE; the ignored request SHALL not be queued.
REQ-025 A, B and sub SHALL be don't-care except on the accepting edge; changes during RUN SHALL not affect the result.
REQ-026 S, Cout and Ovf SHALL hold their values from DONE until the next accepted start.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH; carry out of the MSB appears only on Cout.
REQ-028 Back-to-back operation: start held high SHALL be accepted again in the first IDLE cycle, giving a throughput of one result per WIDTH+2 cycles.

Reset
REQ-029 rst_n=0 SHALL immediately, without a clock, force state IDLE and clear the shift registers, the counter and the carry register.
REQ-030 rst_n=0 SHALL immediately force busy, done, S, Cout and Ovf to 0.
REQ-031 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-032 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification (WIDTH=8)
REQ-033 Bench SHALL cover: A=0x0F, B=0x01, sub=0 -> done 8 cycles after acceptance; S=0x10, Cout=0, Ovf=0.
REQ-034 Bench SHALL cover: A=0xFF, B=0x01, sub=0 -> S=0x00, Cout=1, Ovf=0; then A=0x7F, B=0x01 -> S=0x80, Cout=0, Ovf=1.
REQ-035 Bench SHALL cover: A=0x05, B=0x07, sub=1 -> S=0xFE, Cout=0, Ovf=0; then A=0x80, B=0x01, sub=1 -> S=0x7F, Cout=1, Ovf=1.
REQ-036 Bench SHALL cover: start pulsed with A=0x01, B=0x01, sub=0 at cycles 3 and 5 after acceptance of A=0x10, B=0x20 -> ignored; single done with S=0x30; busy continuous for 9 cycles.
REQ-037 Bench SHALL cover: rst_n pulsed low at RUN bit 4 -> busy=0 and S=0 immediately, no done; next start with A=0x03, B=0x04, sub=0 -> S=0x07.
REQ-038 Bench SHALL cover: start held high with fixed operands -> done pulses exactly 10 cycles apart with identical S.
